add8_err_monitor: RTL and testbench
===================================

# add8_err_monitor

Streaming error-characterisation stage that sits directly downstream of any 8-bit approximate adder in the library. It consumes (A, B, O) triples, computes the exact 9-bit sum, and accumulates MAE/MSE/WCE/EP statistics over a programmed number of samples. It is used in hardware sweeps that validate the library's published metrics.

## Interface
- CNT_W, 17: sample-counter width; a run holds up to 2^CNT_W-1 samples, enough for an exhaustive 65536-pair sweep.
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run; honoured only in IDLE or DONE
- num_samples  in  CNT_W  samples per run; sampled on start
- in_valid  in  1  upstream triple valid
- in_ready  out  1  monitor accepts triple
- in_a, in_b  in  8  adder operands
- in_o  in  9  approximate adder output under test
- busy  out  1  state is RUN or DRAIN
- done  out  1  results final; held until next start or rst
- res_count  out  CNT_W  samples accepted
- res_sae  out  CNT_W+9  sum of |exact-in_o|
- res_sse  out  CNT_W+18  sum of squared errors
- res_wce  out  9  worst-case absolute error
- res_wce_a, res_wce_b  out  8  operands of first sample reaching res_wce
- res_err_cnt  out  CNT_W  samples with nonzero error

## Operation
- Exact sum = {1'b0,in_a}+{1'b0,in_b} (9 bits). err = |exact-in_o| (9 bits, 0..511). sq = err*err (18 bits). Accumulator widths are sized so overflow cannot occur and no saturation is needed.
- FSM states:
  - IDLE: entered on reset.
  - RUN: entered on start. start clears every res_* register and loads num_samples. If num_samples==0, the FSM goes directly to DONE with all results 0.
  - DRAIN: RUN moves to DRAIN after the handshake that makes res_count==num_samples.
  - DONE: DRAIN moves to DONE when both pipeline valid bits are 0.
- start in RUN or DRAIN is ignored. start in DONE restarts the run, behaving exactly as from IDLE.
- in_ready = (state==RUN) && (accepted < num_samples). It is registered-state-derived with no combinational path from in_valid.
- A handshake occurs when in_valid && in_ready. Gaps in in_valid are tolerated. Triples offered while in_ready=0 are not consumed.
- WCE update only on strictly greater err, so ties keep the first occurrence. res_wce_a/b reset to 0.
- res_err_cnt increments when err != 0.

## Timing
- Two-stage pipeline:
  - S1 registers err, sq, a, b and a valid bit.
  - S2 updates the accumulators.
- Handshake at edge k: S1 holds the sample after edge k; accumulators include it after edge k+1.
- res_count counts at the handshake edge, so in_ready drops in the cycle after the last accept.
- Last handshake at edge k: done=1 and busy=0 after edge k+2, and all res_* are final at that point.
- num_samples==0: done=1 after the edge following start.
- Reset values: state IDLE; in_ready, busy, done and all res_* are 0; pipeline valids are 0.
- rst mid-run discards in-flight samples immediately; no partial results persist.

## Structure
- add8_eval_pkg holds:
  - ADD_W=8 and SUM_W=9.
  - the state enum (IDLE, RUN, DRAIN, DONE).
  - accumulator width functions of CNT_W.
- Sub-module add8_exact_err is purely combinational: a, b, o to exact, err, sq. It is instantiated in stage S1 and reusable by other evaluation benches.

## Test plan
- Exact adder: num_samples=4, in_o=a+b -> res_count=4, sae=0, sse=0, wce=0, err_cnt=0; done 2 edges after last accept.
- Known errors: (10,20,o=25), (255,255,o=500), (0,0,o=0) -> sae=15, sse=125, wce=10, wce_a=255, wce_b=255, err_cnt=2.
- Backpressure: num_samples=3, in_valid toggling, 5 triples offered -> exactly 3 accepted; in_ready=0 from cycle after 3rd accept; later triples not counted.
- num_samples=0 -> done=1 one edge after start; all res_*=0. start during RUN has no effect.
- Reset mid-RUN: rst after 2 accepts -> all outputs 0, state IDLE; a fresh start with 1 exact sample -> res_count=1, sae=0.
- Exhaustive sweep: 65536 pairs (a outer, b inner), in_o=exact with bit0 cleared -> sae=32768, sse=32768, wce=1, wce_a=0, wce_b=1, err_cnt=32768.

Source files
------------

// File: rtl/add8_eval_pkg.sv
// add8_eval_pkg: shared widths, FSM states and accumulator sizing for adder evaluation
package add8_eval_pkg;
    localparam int ADD_W = 8;
    localparam int SUM_W = 9;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    function automatic int sae_w(input int cnt_w);
        return cnt_w + SUM_W;
    endfunction
    function automatic int sse_w(input int cnt_w);
        return cnt_w + 2 * SUM_W;
    endfunction
endpackage

// File: rtl/add8_exact_err.sv
// add8_exact_err: exact 9-bit sum, absolute error and squared error of an approximate result
module add8_exact_err
    import add8_eval_pkg::*;
(
    input  logic [ADD_W-1:0]   a,
    input  logic [ADD_W-1:0]   b,
    input  logic [SUM_W-1:0]   o,
    output logic [SUM_W-1:0]   exact,
    output logic [SUM_W-1:0]   err,
    output logic [2*SUM_W-1:0] sq
);
    assign exact = {1'b0, a} + {1'b0, b};
    assign err   = (exact >= o) ? exact - o : o - exact;
    assign sq    = (2*SUM_W)'(err) * (2*SUM_W)'(err);
endmodule

// File: rtl/add8_err_monitor.sv
// add8_err_monitor: accumulates MAE/MSE/WCE/EP statistics over a programmed run of adder samples
module add8_err_monitor
    import add8_eval_pkg::*;
#(
    parameter int CNT_W = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_samples,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADD_W-1:0]        in_a,
    input  logic [ADD_W-1:0]        in_b,
    input  logic [SUM_W-1:0]        in_o,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        res_count,
    output logic [sae_w(CNT_W)-1:0] res_sae,
    output logic [sse_w(CNT_W)-1:0] res_sse,
    output logic [SUM_W-1:0]        res_wce,
    output logic [ADD_W-1:0]        res_wce_a,
    output logic [ADD_W-1:0]        res_wce_b,
    output logic [CNT_W-1:0]        res_err_cnt
);
    localparam int SAE_W = sae_w(CNT_W);
    localparam int SSE_W = sse_w(CNT_W);

    state_t             state, next;
    logic [CNT_W-1:0]   num;
    logic               v1, ne1, hs, go, last;
    logic [SUM_W-1:0]   exact, err, err1;
    logic [2*SUM_W-1:0] sq, sq1;
    logic [ADD_W-1:0]   a1, b1;

    add8_exact_err u_err (.a(in_a), .b(in_b), .o(in_o), .exact(exact), .err(err), .sq(sq));

    assign in_ready = state == RUN && res_count < num;
    assign hs       = in_valid && in_ready;
    assign go       = start && (state == IDLE || state == DONE);
    assign last     = res_count + CNT_W'(1) == num;
    assign busy     = state == RUN || state == DRAIN;
    assign done     = state == DONE;

    // S2 is the accumulator itself, so draining only waits on the S1 valid bit
    always_comb begin
        next = state;
        if (go)
            next = (num_samples == '0) ? DONE : RUN;
        else if (state == RUN && hs && last)
            next = DRAIN;
        else if (state == DRAIN && !v1)
            next = DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            num         <= '0;
            v1          <= 1'b0;
            ne1         <= 1'b0;
            err1        <= '0;
            sq1         <= '0;
            a1          <= '0;
            b1          <= '0;
            res_count   <= '0;
            res_sae     <= '0;
            res_sse     <= '0;
            res_wce     <= '0;
            res_wce_a   <= '0;
            res_wce_b   <= '0;
            res_err_cnt <= '0;
        end else begin
            state <= next;
            if (go) begin
                num         <= num_samples;
                v1          <= 1'b0;
                res_count   <= '0;
                res_sae     <= '0;
                res_sse     <= '0;
                res_wce     <= '0;
                res_wce_a   <= '0;
                res_wce_b   <= '0;
                res_err_cnt <= '0;
            end else begin
                v1 <= hs;
                if (hs) begin
                    res_count <= res_count + CNT_W'(1);
                    err1      <= err;
                    sq1       <= sq;
                    ne1       <= exact != in_o;
                    a1        <= in_a;
                    b1        <= in_b;
                end
                if (v1) begin
                    res_sae <= res_sae + SAE_W'(err1);
                    res_sse <= res_sse + SSE_W'(sq1);
                    if (ne1)
                        res_err_cnt <= res_err_cnt + CNT_W'(1);
                    // strict compare keeps the first sample that reached the maximum
                    if (err1 > res_wce) begin
                        res_wce   <= err1;
                        res_wce_a <= a1;
                        res_wce_b <= b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_add8_err_monitor.sv
// tb_add8_err_monitor: directed checks of run control, statistics and exhaustive sweep
module tb_add8_err_monitor;
    localparam int CNT_W = 17;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_samples = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_a = '0;
    logic [7:0]       in_b = '0;
    logic [8:0]       in_o = '0;
    logic             busy, done;
    logic [CNT_W-1:0] res_count, res_err_cnt;
    logic [CNT_W+8:0] res_sae;
    logic [CNT_W+17:0] res_sse;
    logic [8:0]       res_wce;
    logic [7:0]       res_wce_a, res_wce_b;

    int total = 0;
    int bad = 0;

    add8_err_monitor #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_o(in_o),
        .busy(busy), .done(done), .res_count(res_count), .res_sae(res_sae), .res_sse(res_sse),
        .res_wce(res_wce), .res_wce_a(res_wce_a), .res_wce_b(res_wce_b), .res_err_cnt(res_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        num_samples = CNT_W'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [8:0] o, output bit acc);
        in_a = a;
        in_b = b;
        in_o = o;
        in_valid = 1'b1;
        acc = in_ready;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic res_chk(input string tag, input int cnt, input int sae, input int sse,
                           input int wce, input int wa, input int wb, input int ec);
        chk({tag, "_count"}, 64'(res_count), 64'(cnt));
        chk({tag, "_sae"}, 64'(res_sae), 64'(sae));
        chk({tag, "_sse"}, 64'(res_sse), 64'(sse));
        chk({tag, "_wce"}, 64'(res_wce), 64'(wce));
        chk({tag, "_wce_a"}, 64'(res_wce_a), 64'(wa));
        chk({tag, "_wce_b"}, 64'(res_wce_b), 64'(wb));
        chk({tag, "_err_cnt"}, 64'(res_err_cnt), 64'(ec));
    endtask

    initial begin
        bit acc;
        int n;
        tick();
        tick();
        chk("rst_ready", 64'(in_ready), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        res_chk("rst", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        // exact adder, four samples back to back
        run(4);
        chk("t1_ready", 64'(in_ready), 1);
        push(8'd1, 8'd2, 9'd3, acc);
        push(8'd100, 8'd155, 9'd255, acc);
        push(8'd255, 8'd255, 9'd510, acc);
        push(8'd0, 8'd0, 9'd0, acc);
        chk("t1_ready_drop", 64'(in_ready), 0);
        chk("t1_busy_k", 64'(busy), 1);
        tick();
        chk("t1_done_k1", 64'(done), 0);
        tick();
        chk("t1_done_k2", 64'(done), 1);
        chk("t1_busy_k2", 64'(busy), 0);
        res_chk("t1", 4, 0, 0, 0, 0, 0, 0);

        // known errors: 5, 10, 0
        run(3);
        push(8'd10, 8'd20, 9'd25, acc);
        push(8'd255, 8'd255, 9'd500, acc);
        push(8'd0, 8'd0, 9'd0, acc);
        tick();
        tick();
        chk("t2_done", 64'(done), 1);
        res_chk("t2", 3, 15, 125, 10, 255, 255, 2);

        // backpressure with gaps; only the first three offers are consumed
        run(3);
        n = 0;
        push(8'd1, 8'd1, 9'd3, acc); n += int'(acc);
        tick();
        push(8'd2, 8'd2, 9'd4, acc); n += int'(acc);
        tick();
        push(8'd3, 8'd3, 9'd6, acc); n += int'(acc);
        chk("t3_ready_drop", 64'(in_ready), 0);
        push(8'd4, 8'd4, 9'd0, acc); n += int'(acc);
        push(8'd5, 8'd5, 9'd0, acc); n += int'(acc);
        chk("t3_accepted", 64'(n), 3);
        chk("t3_done", 64'(done), 1);
        res_chk("t3", 3, 1, 1, 1, 1, 1, 1);

        // zero-length run clears results and finishes at once
        run(0);
        chk("t4_done", 64'(done), 1);
        res_chk("t4", 0, 0, 0, 0, 0, 0, 0);

        // start during RUN is ignored
        run(2);
        push(8'd7, 8'd8, 9'd14, acc);
        run(5);
        chk("t4b_busy", 64'(busy), 1);
        push(8'd9, 8'd9, 9'd18, acc);
        tick();
        tick();
        chk("t4b_done", 64'(done), 1);
        res_chk("t4b", 2, 1, 1, 1, 7, 8, 1);

        // asynchronous reset mid-run
        run(5);
        push(8'd10, 8'd20, 9'd25, acc);
        push(8'd255, 8'd255, 9'd500, acc);
        tick();
        rst = 1'b1;
        #1;
        chk("t5_busy", 64'(busy), 0);
        chk("t5_ready", 64'(in_ready), 0);
        chk("t5_done", 64'(done), 0);
        res_chk("t5", 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t5_idle_done", 64'(done), 0);
        run(1);
        push(8'd3, 8'd4, 9'd7, acc);
        tick();
        tick();
        chk("t5b_done", 64'(done), 1);
        res_chk("t5b", 1, 0, 0, 0, 0, 0, 0);

        // exhaustive sweep with bit 0 of the exact sum cleared
        run(65536);
        n = 0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                push(8'(a), 8'(b), (9'(a) + 9'(b)) & 9'h1FE, acc);
                n += int'(acc);
            end
        end
        chk("t6_accepted", 64'(n), 65536);
        n = 0;
        while (!done && n < 10) begin
            tick();
            n++;
        end
        chk("t6_done", 64'(done), 1);
        res_chk("t6", 65536, 32768, 32768, 1, 0, 1, 32768);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
